// File: rtl/bch_enc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bch_enc_sequencer
// Brief    : Feeds a K-bit message serially into a BCH(63,51) LFSR encoder and
//            emits codeword framing strobes aligned with the encoder's dout.
// Revision : 1.0 - initial release
// ============================================================================
module bch_enc_sequencer #(
  parameter int K         = 51,
  parameter int N         = 63,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [K-1:0] msg_data,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic         flush,
  output logic         enc_din,
  output logic         enc_switch,
  output logic         enc_init,
  output logic         cw_valid,
  output logic         cw_sop,
  output logic         cw_eop,
  output logic         busy
);

  localparam int c_P     = N - K;
  localparam int c_CNT_W = $clog2(K);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_INIT  = 3'd1;
  localparam logic [2:0] c_ST_MSG   = 3'd2;
  localparam logic [2:0] c_ST_PAR   = 3'd3;
  localparam logic [2:0] c_ST_ABORT = 3'd4;

  localparam logic [c_CNT_W-1:0] c_CNT_MSG_LAST = c_CNT_W'(K - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_PAR_LAST = c_CNT_W'(c_P - 1);

  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [K-1:0]       r_sreg;

  logic [2:0]         w_nxt_state;
  logic [c_CNT_W-1:0] w_nxt_cnt;
  logic               w_abort;
  logic               w_xfer;
  logic               w_head;
  logic [K-1:0]       w_sreg_shift;

  // flush outranks a transfer offered in the same cycle
  assign w_abort      = flush && (r_state != c_ST_IDLE);
  assign w_xfer       = msg_valid && msg_ready && !w_abort;
  assign w_head       = MSB_FIRST ? r_sreg[K-1] : r_sreg[0];
  assign w_sreg_shift = MSB_FIRST ? {r_sreg[K-2:0], 1'b0} : {1'b0, r_sreg[K-1:1]};

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    if (w_abort) begin
      w_nxt_state = c_ST_ABORT;
      w_nxt_cnt   = '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          w_nxt_cnt = '0;
          if (w_xfer) w_nxt_state = c_ST_INIT;
        end
        c_ST_INIT: begin
          w_nxt_state = c_ST_MSG;
          w_nxt_cnt   = '0;
        end
        c_ST_MSG: begin
          if (r_cnt == c_CNT_MSG_LAST) begin
            w_nxt_state = c_ST_PAR;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
        end
        c_ST_PAR: begin
          if (r_cnt == c_CNT_PAR_LAST) begin
            w_nxt_state = w_xfer ? c_ST_INIT : c_ST_IDLE;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
        end
        c_ST_ABORT: begin
          w_nxt_state = c_ST_IDLE;
          w_nxt_cnt   = '0;
        end
        default: begin
          w_nxt_state = c_ST_IDLE;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      if (w_xfer) begin
        r_sreg <= msg_data;
      end else if (w_nxt_state == c_ST_MSG) begin
        r_sreg <= w_sreg_shift;
      end
    end
  end

  // Outputs are decoded from the next state so they line up with r_state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_ready  <= 1'b0;
      enc_din    <= 1'b0;
      enc_switch <= 1'b0;
      enc_init   <= 1'b0;
      cw_valid   <= 1'b0;
      cw_sop     <= 1'b0;
      cw_eop     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      msg_ready  <= (w_nxt_state == c_ST_IDLE) ||
                    ((w_nxt_state == c_ST_PAR) && (w_nxt_cnt == c_CNT_PAR_LAST));
      enc_din    <= (w_nxt_state == c_ST_MSG) && w_head;
      enc_switch <= (w_nxt_state == c_ST_MSG);
      enc_init   <= (w_nxt_state == c_ST_INIT) || (w_nxt_state == c_ST_ABORT);
      cw_valid   <= (w_nxt_state == c_ST_MSG) || (w_nxt_state == c_ST_PAR);
      cw_sop     <= (w_nxt_state == c_ST_MSG) && (w_nxt_cnt == '0);
      cw_eop     <= (w_nxt_state == c_ST_PAR) && (w_nxt_cnt == c_CNT_PAR_LAST);
      busy       <= (w_nxt_state != c_ST_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bch_enc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_enc_sequencer
// Brief    : Self-checking bench; a serial BCH encoder stand-in consumes the
//            sequencer outputs and captured codewords are scored.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bch_enc_sequencer;
  localparam int K = 51;
  localparam int N = 63;
  localparam int P = 12;
  localparam logic [P:0] GEN = 13'h1539;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [K-1:0] msg_data = '0;
  logic         msg_valid = 1'b0;
  logic         flush = 1'b0;
  logic         msg_ready, enc_din, enc_switch, enc_init;
  logic         cw_valid, cw_sop, cw_eop, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bch_enc_sequencer #(.K(K), .N(N), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .flush(flush), .enc_din(enc_din),
    .enc_switch(enc_switch), .enc_init(enc_init), .cw_valid(cw_valid),
    .cw_sop(cw_sop), .cw_eop(cw_eop), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream serial encoder stand-in
  logic [P-1:0] lfsr = '0;
  logic         dout;
  assign dout = enc_switch ? enc_din : lfsr[P-1];
  always @(posedge clk) begin
    if (enc_init)        lfsr <= '0;
    else if (enc_switch) lfsr <= {lfsr[P-2:0], 1'b0} ^ ((enc_din ^ lfsr[P-1]) ? GEN[P-1:0] : '0);
    else                 lfsr <= {lfsr[P-2:0], 1'b0};
  end

  // Remainder of m(x)*x^P divided by g(x), by long division
  function automatic logic [P-1:0] ref_parity(input logic [K-1:0] m);
    logic [N-1:0] v;
    logic [N-1:0] g;
    v = {m, {P{1'b0}}};
    g = N'(GEN);
    for (int i = N - 1; i >= P; i--)
      if (v[i]) v = v ^ (g << (i - P));
    return v[P-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted messages in order, captured codewords compared on eop
  logic [K-1:0] expq[$];
  logic [N-1:0] cap = '0;
  logic [N-1:0] last_cw = '0;
  int           ncap = 0;
  int           rx_frames = 0;

  always @(negedge clk) begin
    logic [K-1:0] m;
    if (reset) begin
      if (msg_valid && msg_ready && !flush) expq.push_back(msg_data);
      if (cw_valid) begin
        if (cw_sop) begin
          cap  = '0;
          ncap = 0;
        end
        cap = {cap[N-2:0], dout};
        ncap++;
        if (cw_eop) begin
          rx_frames++;
          last_cw = cap;
          check("frame_len", 64'(ncap), 64'd63);
          if (expq.size() == 0) begin
            check("frame_unexpected", 64'd1, 64'd0);
          end else begin
            m = expq.pop_front();
            check("codeword", 64'(cap), 64'({m, ref_parity(m)}));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [K-1:0] d, input bit hold, output int xc);
    bit done;
    done = 1'b0;
    xc = -1;
    msg_data  = d;
    msg_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      if (msg_ready) begin
        tick();
        xc = cyc;
        done = 1'b1;
      end else begin
        tick();
      end
    end
    if (!hold) msg_valid = 1'b0;
    if (!done) check("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (expq.size() == 0 && !busy) done = 1'b1;
      else tick();
    end
    if (!done) check("drain_timeout", 64'd1, 64'd0);
  endtask

  typedef struct packed {
    logic [K-1:0] msg;
    logic [P-1:0] par;
  } vec_t;

  vec_t tab[10];

  initial begin
    int x1, x2, f0, nv;
    logic [K-1:0] rm;

    tab[0] = '{msg: 51'h0, par: 12'h000};
    tab[1] = '{msg: 51'h1, par: 12'h539};
    tab[2] = '{msg: 51'h2, par: 12'hA72};
    tab[3] = '{msg: 51'h3, par: 12'hF4B};
    tab[4] = '{msg: 51'h4, par: 12'h1DD};
    for (int i = 5; i < 10; i++) begin
      tab[i].msg = K'({$urandom(), $urandom()});
      tab[i].par = ref_parity(tab[i].msg);
    end

    // Reset state and release
    repeat (3) tick();
    check("reset_outputs", 64'({msg_ready, enc_din, enc_switch, enc_init, cw_valid, cw_sop, cw_eop, busy}), 64'd0);
    reset = 1'b1;
    check("ready_before_edge", 64'(msg_ready), 64'd0);
    tick();
    check("ready_after_release", 64'(msg_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    // Latency and framing for 51'h1
    send(51'h1, 1'b0, x1);
    check("init_cycle", 64'({enc_init, enc_switch, cw_valid, msg_ready, busy}), 64'b10001);
    tick();
    check("sop_cycle", 64'({cw_sop, enc_switch, cw_valid, enc_din, enc_init}), 64'b11100);
    repeat (50) tick();
    check("last_msg_bit", 64'({enc_din, enc_switch, cw_sop}), 64'b110);
    tick();
    check("par_first", 64'({enc_switch, cw_valid, enc_din}), 64'b010);
    repeat (11) tick();
    check("eop_cycle", 64'({cw_eop, msg_ready, cw_valid}), 64'b111);
    tick();
    check("back_idle", 64'({busy, cw_valid, msg_ready, enc_init}), 64'b0010);
    check("cw_h1", 64'(last_cw), 64'({51'h1, 12'h539}));

    // Table of messages with known parities
    for (int t = 0; t < 10; t++) begin
      f0 = rx_frames;
      send(tab[t].msg, 1'b0, x1);
      drain();
      check("table_frames", 64'(rx_frames - f0), 64'd1);
      check("table_cw", 64'(last_cw), 64'({tab[t].msg, tab[t].par}));
    end

    // Back-to-back frames
    f0 = rx_frames;
    send(51'h1, 1'b1, x1);
    msg_data = 51'h0;
    for (int i = 0; i < 200 && !msg_ready; i++) tick();
    check("b2b_eop_with_ready", 64'({cw_eop, msg_ready}), 64'b11);
    tick();
    x2 = cyc;
    msg_valid = 1'b0;
    check("b2b_init", 64'({enc_init, cw_valid}), 64'b10);
    check("b2b_spacing", 64'(x2 - x1), 64'd64);
    drain();
    check("b2b_frames", 64'(rx_frames - f0), 64'd2);
    check("b2b_parity2", 64'(last_cw[P-1:0]), 64'h000);

    // Backpressure: second message offered mid-frame
    f0 = rx_frames;
    send(51'h5A5A5A5A5A5A5, 1'b0, x1);
    repeat (10) tick();
    check("bp_ready_low", 64'(msg_ready), 64'd0);
    send(51'h123456789ABCD, 1'b0, x2);
    check("bp_spacing", 64'(x2 - x1), 64'd64);
    drain();
    check("bp_frames", 64'(rx_frames - f0), 64'd2);

    // Flush at MSG cnt 20
    send(51'h1, 1'b0, x1);
    tick();
    repeat (20) tick();
    f0 = rx_frames;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_abort", 64'({enc_init, cw_valid, enc_switch, enc_din, cw_sop, cw_eop, msg_ready}), 64'b1000000);
    tick();
    check("flush_idle", 64'({busy, msg_ready, enc_init}), 64'b010);
    check("flush_q", 64'(expq.size()), 64'd1);
    if (expq.size() > 0) expq.delete(0);
    repeat (5) tick();
    check("flush_no_eop", 64'(rx_frames - f0), 64'd0);
    send(51'h1, 1'b0, x1);
    drain();
    check("flush_next_parity", 64'(last_cw[P-1:0]), 64'h539);

    // Reset asserted mid-frame
    send(K'({$urandom(), $urandom()}), 1'b0, x1);
    repeat (10) tick();
    #2;
    reset = 1'b0;
    #1;
    check("reset_mid_frame", 64'({msg_ready, enc_din, enc_switch, enc_init, cw_valid, cw_sop, cw_eop, busy}), 64'd0);
    check("reset_q", 64'(expq.size()), 64'd1);
    if (expq.size() > 0) expq.delete(0);
    repeat (2) tick();
    reset = 1'b1;
    check("rst_ready_before", 64'(msg_ready), 64'd0);
    tick();
    check("rst_ready_after", 64'({msg_ready, busy}), 64'b10);
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      if (cw_valid || cw_sop || cw_eop) nv++;
      tick();
    end
    check("rst_no_strobes", 64'(nv), 64'd0);
    send(51'h1, 1'b0, x1);
    drain();
    check("rst_next_parity", 64'(last_cw[P-1:0]), 64'h539);

    // Random traffic with random gaps
    f0 = rx_frames;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      rm = K'({$urandom(), $urandom()});
      send(rm, 1'b0, x1);
    end
    drain();
    check("rand_frames", 64'(rx_frames - f0), 64'd20);
    check("rand_queue_empty", 64'(expq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
